ets_multi_accum: RTL and testbench

- Parametrised multi-channel equivalent-time-sampling accumulator.
- Over a programmable number of triggered sample cycles, it counts how many of those cycles had each channel's comparator bit high.
- The per-channel hit counts form the ETS reconstruction value for the current delay step. It sits between the comparator front-end and the sweep controller, which issues start, waits for done, then reads the data.

---
 rtl/ets_multi_accum.sv | 101 ++++++++++
 tb/tb_ets_multi_accum.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ets_multi_accum.sv
// Multi-channel equivalent-time-sampling accumulator.
// Counts comparator-high cycles per channel over a programmed number of triggers.
module ets_multi_accum #(
  parameter int CH    = 4,
  parameter int CNT_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CNT_W-1:0]    average,
  input  logic [CH-1:0]       ch_mask,
  input  logic [CH-1:0]       data_in,
  input  logic                trigger,
  input  logic                start,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  output logic [CNT_W-1:0]    sample_cnt,
  output logic [CH*CNT_W-1:0] data
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [1:0] S_CLR  = 2'd3;

  logic [1:0]       state;
  logic [1:0]       state_nx;
  logic [CNT_W-1:0] avg_q;
  logic [CH-1:0]    mask_q;
  logic             last;

  // full-width unsigned compare; cnt+1 cannot wrap before reaching avg_q
  assign last = trigger && ((sample_cnt + CNT_W'(1)) == avg_q);

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (start)
          state_nx = (average == '0) ? S_DONE : S_BUSY;
      end
      S_BUSY: begin
        if (abort)
          state_nx = S_CLR;
        else if (last)
          state_nx = S_DONE;
      end
      S_DONE: begin
        if (abort || !start)
          state_nx = S_CLR;
      end
      S_CLR: begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      avg_q  <= '0;
      mask_q <= '0;
    end else begin
      state <= state_nx;
      busy  <= (state_nx == S_BUSY);
      done  <= (state_nx == S_DONE);
      if (state == S_IDLE && start) begin
        avg_q  <= average;
        mask_q <= ch_mask;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_cnt <= '0;
      data       <= '0;
    end else begin
      unique case (1'b1)
        (state == S_CLR): begin
          sample_cnt <= '0;
          data       <= '0;
        end
        (state == S_BUSY && !abort && trigger): begin
          sample_cnt <= sample_cnt + CNT_W'(1);
          for (int i = 0; i < CH; i++)
            data[i*CNT_W +: CNT_W] <= data[i*CNT_W +: CNT_W]
              + CNT_W'(data_in[i] & mask_q[i]);
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ets_multi_accum.sv
// Directed testbench for ets_multi_accum.
// Each task drives one scenario and checks against hand-computed values.
module tb_ets_multi_accum;

  localparam int CH    = 4;
  localparam int CNT_W = 32;

  logic                clk;
  logic                rst_n;
  logic [CNT_W-1:0]    average;
  logic [CH-1:0]       ch_mask;
  logic [CH-1:0]       data_in;
  logic                trigger;
  logic                start;
  logic                abort;
  logic                busy;
  logic                done;
  logic [CNT_W-1:0]    sample_cnt;
  logic [CH*CNT_W-1:0] data;

  int checks;
  int failures;

  ets_multi_accum #(.CH(CH), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .average(average),
    .ch_mask(ch_mask),
    .data_in(data_in),
    .trigger(trigger),
    .start(start),
    .abort(abort),
    .busy(busy),
    .done(done),
    .sample_cnt(sample_cnt),
    .data(data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // returns edges until done (or -1 on timeout)
  task automatic wait_done(input int limit, output int n);
    n = 0;
    while (!done && n < limit) begin
      step();
      n++;
    end
    if (!done) n = -1;
  endtask

  task automatic finish_acq();
    start   = 1'b0;
    trigger = 1'b0;
    step();
    step();
  endtask

  task automatic test_reset();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags busy=%b done=%b want 0 0", busy, done);
    end
    checks++;
    if (sample_cnt !== '0 || data !== '0) begin
      failures++;
      $display("FAIL reset_data cnt=%0d data=%h want 0", sample_cnt, data);
    end
  endtask

  task automatic test_basic();
    int n;
    average = 8;
    ch_mask = 4'hF;
    data_in = 4'b0101;
    trigger = 1'b1;
    start   = 1'b1;
    step();
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL basic_busy got=%b want 1", busy);
    end
    wait_done(20, n);
    n = n + 1;
    checks++;
    if (n !== 9) begin
      failures++;
      $display("FAIL basic_latency got=%0d want 9", n);
    end
    checks++;
    if (data[0 +: 32] !== 8 || data[32 +: 32] !== 0 ||
        data[64 +: 32] !== 8 || data[96 +: 32] !== 0) begin
      failures++;
      $display("FAIL basic_data got=%h want 0/8/0/8", data);
    end
    checks++;
    if (sample_cnt !== 8 || busy !== 1'b0) begin
      failures++;
      $display("FAIL basic_cnt got=%0d busy=%b want 8 0", sample_cnt, busy);
    end
    step();
    checks++;
    if (done !== 1'b1 || sample_cnt !== 8) begin
      failures++;
      $display("FAIL done_hold done=%b cnt=%0d want 1 8", done, sample_cnt);
    end
    start = 1'b0;
    step();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL clr_flags done=%b busy=%b want 0 0", done, busy);
    end
    step();
    checks++;
    if (sample_cnt !== '0 || data !== '0) begin
      failures++;
      $display("FAIL clr_data cnt=%0d data=%h want 0", sample_cnt, data);
    end
    trigger = 1'b0;
  endtask

  task automatic test_toggle_trigger();
    int k;
    average = 5;
    ch_mask = 4'hF;
    data_in = 4'hF;
    trigger = 1'b0;
    start   = 1'b1;
    step();
    k = 0;
    while (!done && k < 30) begin
      trigger = (k % 2 == 0);
      step();
      k++;
    end
    checks++;
    if (done !== 1'b1 || k !== 9) begin
      failures++;
      $display("FAIL toggle_cycles got=%0d done=%b want 9 1", k, done);
    end
    checks++;
    if (data !== {4{32'd5}} || sample_cnt !== 5) begin
      failures++;
      $display("FAIL toggle_data got=%h cnt=%0d want all 5", data, sample_cnt);
    end
    finish_acq();
  endtask

  task automatic test_mask_latch();
    int n;
    average = 6;
    ch_mask = 4'b1001;
    data_in = 4'hF;
    trigger = 1'b1;
    start   = 1'b1;
    step();
    ch_mask = 4'hF;
    average = 2;
    wait_done(20, n);
    checks++;
    if (n !== 6) begin
      failures++;
      $display("FAIL mask_latency got=%0d want 6", n);
    end
    checks++;
    if (data !== {32'd6, 32'd0, 32'd0, 32'd6}) begin
      failures++;
      $display("FAIL mask_data got=%h want 6/0/0/6", data);
    end
    finish_acq();
  endtask

  task automatic test_zero_average();
    average = 0;
    ch_mask = 4'hF;
    data_in = 4'hF;
    trigger = 1'b1;
    start   = 1'b1;
    step();
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL zero_flags done=%b busy=%b want 1 0", done, busy);
    end
    checks++;
    if (sample_cnt !== '0 || data !== '0) begin
      failures++;
      $display("FAIL zero_data cnt=%0d data=%h want 0", sample_cnt, data);
    end
    finish_acq();
  endtask

  task automatic test_abort();
    int n;
    int seen_done;
    average = 100;
    ch_mask = 4'hF;
    data_in = 4'hF;
    trigger = 1'b1;
    start   = 1'b1;
    step();
    seen_done = 0;
    repeat (40) begin
      step();
      if (done) seen_done++;
    end
    checks++;
    if (sample_cnt !== 40 || seen_done !== 0) begin
      failures++;
      $display("FAIL abort_pre cnt=%0d done_seen=%0d want 40 0",
               sample_cnt, seen_done);
    end
    abort = 1'b1;
    start = 1'b0;
    step();
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL abort_clr busy=%b done=%b want 0 0", busy, done);
    end
    step();
    checks++;
    if (sample_cnt !== '0 || data !== '0 || done !== 1'b0) begin
      failures++;
      $display("FAIL abort_idle cnt=%0d data=%h want 0", sample_cnt, data);
    end
    average = 3;
    start   = 1'b1;
    wait_done(20, n);
    checks++;
    if (n !== 4 || sample_cnt !== 3 || data !== {4{32'd3}}) begin
      failures++;
      $display("FAIL abort_restart n=%0d cnt=%0d want 4 3", n, sample_cnt);
    end
    finish_acq();
  endtask

  task automatic test_async_reset();
    int n;
    average = 100;
    ch_mask = 4'hF;
    data_in = 4'hF;
    trigger = 1'b1;
    start   = 1'b1;
    step();
    repeat (10) step();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 ||
        sample_cnt !== '0 || data !== '0) begin
      failures++;
      $display("FAIL async_reset busy=%b done=%b cnt=%0d data=%h want 0",
               busy, done, sample_cnt, data);
    end
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    average = 4;
    start   = 1'b1;
    wait_done(20, n);
    checks++;
    if (n !== 5 || sample_cnt !== 4 || data !== {4{32'd4}}) begin
      failures++;
      $display("FAIL post_reset n=%0d cnt=%0d data=%h want 5 4",
               n, sample_cnt, data);
    end
    finish_acq();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    average  = '0;
    ch_mask  = '0;
    data_in  = '0;
    trigger  = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    #12;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    test_basic();
    test_toggle_trigger();
    test_mask_latch();
    test_zero_average();
    test_abort();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
